// File: rtl/iir_seq_ctrl_pkg.sv
// Shared select codes, state encoding and output decode for the biquad sequencer.
// The coefficient-operand multiplexer imports the same codes.
package iir_seq_ctrl_pkg;

    // Coefficient select (controlS)
    typedef enum logic [2:0] {
        CS_ZERO = 3'b000,
        CS_A1   = 3'b001,
        CS_A2   = 3'b010,
        CS_B0   = 3'b011,
        CS_B1   = 3'b100,
        CS_B2   = 3'b101
    } sel_s_e;

    // State-operand select (controlC)
    typedef enum logic [1:0] {
        CC_ZERO = 2'b00,
        CC_FK1  = 2'b01,
        CC_FK2  = 2'b10,
        CC_FK   = 2'b11
    } sel_c_e;

    // Addend select (controlZ); CZ_YK is a mux input this sequencer never selects
    typedef enum logic [2:0] {
        CZ_ZERO  = 3'b000,
        CZ_UK    = 3'b001,
        CZ_YK    = 3'b010,
        CZ_ACUM1 = 3'b011,
        CZ_ACUM2 = 3'b100,
        CZ_ACUM3 = 3'b101
    } sel_z_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_S4    = 3'd4,
        ST_S5    = 3'd5,
        ST_SHIFT = 3'd6
    } state_e;

    localparam int unsigned WAIT_W = 3;

    typedef struct packed {
        sel_s_e sel_s;
        sel_c_e sel_c;
        sel_z_e sel_z;
        logic   en_acum1;
        logic   en_fk;
        logic   en_acum2;
        logic   en_acum3;
        logic   en_yk;
        logic   en_shift;
        logic   busy;
        logic   done;
    } ctrl_out_t;

    // Output word for a given state; 'last' marks the final wait cycle of a MAC step.
    function automatic ctrl_out_t decode_outputs(input state_e st, input logic last);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_S1: begin
                o.sel_s    = CS_A1;
                o.sel_c    = CC_FK1;
                o.sel_z    = CZ_UK;
                o.en_acum1 = last;
                o.busy     = 1'b1;
            end
            ST_S2: begin
                o.sel_s    = CS_A2;
                o.sel_c    = CC_FK2;
                o.sel_z    = CZ_ACUM1;
                o.en_fk    = last;
                o.busy     = 1'b1;
            end
            ST_S3: begin
                o.sel_s    = CS_B0;
                o.sel_c    = CC_FK;
                o.sel_z    = CZ_ZERO;
                o.en_acum2 = last;
                o.busy     = 1'b1;
            end
            ST_S4: begin
                o.sel_s    = CS_B1;
                o.sel_c    = CC_FK1;
                o.sel_z    = CZ_ACUM2;
                o.en_acum3 = last;
                o.busy     = 1'b1;
            end
            ST_S5: begin
                o.sel_s    = CS_B2;
                o.sel_c    = CC_FK2;
                o.sel_z    = CZ_ACUM3;
                o.en_yk    = last;
                o.busy     = 1'b1;
            end
            ST_SHIFT: begin
                o.en_shift = 1'b1;
                o.done     = 1'b1;
                o.busy     = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/iir_seq_ctrl_step_timer.sv
// Per-step wait counter: cleared on step entry, flags the last of MAC_LAT+1 cycles.
// o_last_nxt lets the sequencer register its outputs one cycle ahead.
module step_timer
    import iir_seq_ctrl_pkg::*;
#(
    parameter int unsigned MAC_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_last,
    output logic o_last_nxt
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAC_LAT);

    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = i_clear ? '0 : r_cnt + WAIT_W'(1);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_last     = (r_cnt == LAST);
    assign o_last_nxt = (w_cnt_nxt == LAST);

endmodule

// File: rtl/iir_seq_ctrl.sv
// Biquad control sequencer: walks five MAC steps and a delay-line shift per input
// sample, driving the operand-mux selects and datapath load enables (all registered).
module iir_seq_ctrl
    import iir_seq_ctrl_pkg::*;
#(
    parameter int unsigned MAC_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_acum1,
    output logic       en_fk,
    output logic       en_acum2,
    output logic       en_acum3,
    output logic       en_yk,
    output logic       en_shift,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    state_e    r_state;
    state_e    w_state_nxt;
    ctrl_out_t r_out;
    logic      r_overrun;
    logic      w_last;
    logic      w_last_nxt;
    logic      w_clear;

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_S1;
            ST_S1:    if (w_last) w_state_nxt = ST_S2;
            ST_S2:    if (w_last) w_state_nxt = ST_S3;
            ST_S3:    if (w_last) w_state_nxt = ST_S4;
            ST_S4:    if (w_last) w_state_nxt = ST_S5;
            ST_S5:    if (w_last) w_state_nxt = ST_SHIFT;
            ST_SHIFT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // The counter only runs while a MAC step is held; any state change restarts it at 0.
    assign w_clear = (w_state_nxt != r_state) || (w_state_nxt == ST_IDLE);

    step_timer #(
        .MAC_LAT (MAC_LAT)
    ) u_step_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .o_last     (w_last),
        .o_last_nxt (w_last_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_out     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= decode_outputs(w_state_nxt, w_last_nxt);
            if (start && r_out.busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign controlS = r_out.sel_s;
    assign controlC = r_out.sel_c;
    assign controlZ = r_out.sel_z;
    assign en_acum1 = r_out.en_acum1;
    assign en_fk    = r_out.en_fk;
    assign en_acum2 = r_out.en_acum2;
    assign en_acum3 = r_out.en_acum3;
    assign en_yk    = r_out.en_yk;
    assign en_shift = r_out.en_shift;
    assign busy     = r_out.busy;
    assign done     = r_out.done;
    assign overrun  = r_overrun;

endmodule
